// File: rtl/upd78_alu_pkg.sv
// Shared types and helpers for the uPD78xx W-bit ALU.
package upd78_alu_pkg;

    // Operation codes as issued by the sequencer.
    typedef enum logic [3:0] {
        OpSum   = 4'd0,
        OpInc   = 4'd1,
        OpDec   = 4'd2,
        OpOr    = 4'd3,
        OpAnd   = 4'd4,
        OpEor   = 4'd5,
        OpAsl   = 4'd6,
        OpRol   = 4'd7,
        OpLsr   = 4'd8,
        OpRor   = 4'd9,
        OpDaa   = 4'd10,
        OpDas   = 4'd11,
        OpMul   = 4'd12,
        OpDiv   = 4'd13,
        OpRsv14 = 4'd14,
        OpRsv15 = 4'd15
    } e_aluop;

    // MUL/DIV iterator states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2
    } e_alust;

    localparam logic [3:0] BcdNibMax  = 4'h9;
    localparam logic [7:0] BcdByteMax = 8'h99;
    localparam logic [3:0] BcdAdj     = 4'h6;

    // Decimal adjust constant (0x00/0x06/0x60/0x66) for DAA/DAS on the low byte.
    function automatic logic [7:0] bcd_adjust(input logic [7:0] a, input logic hc,
                                              input logic cy);
        logic lo_adj;
        logic hi_adj;
        lo_adj = hc || (a[3:0] > BcdNibMax);
        hi_adj = cy || (a > BcdByteMax);
        return {(hi_adj ? BcdAdj : 4'h0), (lo_adj ? BcdAdj : 4'h0)};
    endfunction

endpackage

// File: rtl/upd78_alu_muldiv.sv
// W-step iterator for unsigned shift-add multiply and restoring divide.
// o_lo/o_hi carry the value of the step being taken this tick, so the parent
// can register the final result on the same tick that o_done is raised.
module upd78_alu_muldiv
    import upd78_alu_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ce,
    input  logic         i_start_mul,
    input  logic         i_start_div,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_is_mul,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam logic [CW-1:0] LastCnt = CW'(W - 1);

    e_alust        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_lo;   // multiplier / dividend shifting out, product-low / quotient in
    logic [W-1:0]  r_hi;   // partial product high / partial remainder
    logic [W-1:0]  r_opb;  // multiplicand / divisor

    logic [W:0]    w_mul_sum;
    logic [W:0]    w_div_shift;
    logic          w_div_ge;
    logic [W-1:0]  w_div_sub;
    logic [W-1:0]  w_step_lo;
    logic [W-1:0]  w_step_hi;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_div_shift = {r_hi, r_lo[W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    // Remainder always fits W bits once the trial subtract succeeds.
    assign w_div_sub   = W'(w_div_shift - {1'b0, r_opb});

    // One iteration step of whichever operation is in flight.
    always_comb begin
        if (r_state == StMul) begin
            w_step_hi = w_mul_sum[W:1];
            w_step_lo = {w_mul_sum[0], r_lo[W-1:1]};
        end else if (w_div_ge) begin
            w_step_hi = w_div_sub;
            w_step_lo = {r_lo[W-2:0], 1'b1};
        end else begin
            w_step_hi = w_div_shift[W-1:0];
            w_step_lo = {r_lo[W-2:0], 1'b0};
        end
    end

    assign o_busy   = (r_state != StIdle);
    assign o_done   = i_ce && o_busy && (r_cnt == LastCnt);
    assign o_is_mul = (r_state == StMul);
    assign o_lo     = w_step_lo;
    assign o_hi     = w_step_hi;

    // Iterator FSM: latch operands on issue, then one bit per CE tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_opb   <= '0;
        end else if (i_ce) begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    if (i_start_mul) begin
                        r_state <= StMul;
                        r_lo    <= i_b;
                        r_opb   <= i_a;
                    end else if (i_start_div) begin
                        r_state <= StDiv;
                        r_lo    <= i_a;
                        r_opb   <= i_b;
                    end
                end
                StMul, StDiv: begin
                    r_lo  <= w_step_lo;
                    r_hi  <= w_step_hi;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LastCnt) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/upd78_alu.sv
// W-bit strobe-clocked ALU for the uPD78xx family: single-cycle arithmetic,
// logic, shift and BCD ops plus iterative MUL/DIV with registered results.
module upd78_alu
    import upd78_alu_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 5
) (
    input  logic         CLK,
    input  logic         RESETB,
    input  logic         CE,
    input  logic         START,
    input  logic [3:0]   OP,
    input  logic         BIN,
    input  logic         CIN,
    input  logic         CYIN,
    input  logic         HCIN,
    input  logic [W-1:0] AI,
    input  logic [W-1:0] BI,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] CO,
    output logic [W-1:0] COH,
    output logic         CCO,
    output logic         CHO,
    output logic         ZO,
    output logic         VO
);

    if (W < 8) begin : g_bad_w
        $error("upd78_alu: W must be at least 8");
    end
    if ((2 ** CW) <= W) begin : g_bad_cw
        $error("upd78_alu: 2**CW must exceed W");
    end

    e_aluop       w_op;
    logic         w_busy;
    logic         w_md_done;
    logic         w_md_is_mul;
    logic [W-1:0] w_md_lo;
    logic [W-1:0] w_md_hi;

    logic         w_inv;
    logic         w_cin;
    logic [W-1:0] w_b_eff;
    logic [W:0]   w_sum;
    logic         w_hc;
    logic         w_ovf;
    logic [7:0]   w_bcd_adj;
    logic         w_bcd_hi;
    logic [7:0]   w_daa;
    logic [7:0]   w_das;

    logic         w_div_zero;
    logic         w_start_mul;
    logic         w_start_div;
    logic         w_issue_sc;

    logic [W-1:0] w_res;
    logic [W-1:0] w_resh;
    logic         w_cco;
    logic         w_cho;
    logic         w_vo;

    logic [W-1:0] r_co;
    logic [W-1:0] r_coh;
    logic         r_cco;
    logic         r_cho;
    logic         r_zo;
    logic         r_vo;
    logic         r_done;

    assign w_op = e_aluop'(OP);

    // SUM, INC and DEC share one adder: INC adds CIN=1, DEC adds an inverted zero.
    assign w_inv   = (w_op == OpSum) ? BIN : (w_op == OpDec);
    assign w_b_eff = (w_op == OpSum) ? (BIN ? ~BI : BI) : ((w_op == OpDec) ? '1 : '0);
    assign w_cin   = (w_op == OpSum) ? CIN : (w_op == OpInc);
    assign w_sum   = {1'b0, AI} + {1'b0, w_b_eff} + {{W{1'b0}}, w_cin};
    // Carry into bit 4 recovered from the sum bit and its two addend bits.
    assign w_hc    = w_sum[4] ^ AI[4] ^ w_b_eff[4];
    assign w_ovf   = (AI[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != AI[W-1]);

    assign w_bcd_adj = bcd_adjust(AI[7:0], HCIN, CYIN);
    assign w_bcd_hi  = |w_bcd_adj[7:4];
    assign w_daa     = AI[7:0] + w_bcd_adj;
    assign w_das     = AI[7:0] - w_bcd_adj;

    // Divide by zero completes at issue instead of entering the iterator.
    assign w_div_zero  = (BI == '0);
    assign w_start_mul = START && !w_busy && (w_op == OpMul);
    assign w_start_div = START && !w_busy && (w_op == OpDiv) && !w_div_zero;
    assign w_issue_sc  = START && !w_busy && (w_op != OpMul)
                         && !((w_op == OpDiv) && !w_div_zero);

    // Single-cycle result and flags; logic ops leave CCO/CHO/VO as they were.
    always_comb begin
        w_res  = AI;
        w_resh = '0;
        w_cco  = r_cco;
        w_cho  = r_cho;
        w_vo   = r_vo;
        case (w_op)
            OpSum, OpInc, OpDec: begin
                w_res = w_sum[W-1:0];
                w_cco = w_sum[W] ^ w_inv;
                w_cho = w_hc ^ w_inv;
                w_vo  = w_ovf;
            end
            OpOr:  w_res = AI | BI;
            OpAnd: w_res = AI & BI;
            OpEor: w_res = AI ^ BI;
            OpAsl: begin
                w_res = {AI[W-2:0], 1'b0};
                w_cco = AI[W-1];
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpRol: begin
                w_res = {AI[W-2:0], CIN};
                w_cco = AI[W-1];
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpLsr: begin
                w_res = {1'b0, AI[W-1:1]};
                w_cco = AI[0];
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpRor: begin
                w_res = {CIN, AI[W-1:1]};
                w_cco = AI[0];
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpDaa: begin
                w_res = W'(w_daa);
                w_cco = CYIN | w_bcd_hi;
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpDas: begin
                w_res = W'(w_das);
                w_cco = CYIN;
                w_cho = 1'b0;
                w_vo  = 1'b0;
            end
            OpDiv: begin
                // Only reached for a zero divisor.
                w_res  = '1;
                w_resh = AI;
                w_cco  = 1'b1;
                w_cho  = 1'b0;
                w_vo   = 1'b0;
            end
            default: ;  // reserved codes pass AI with flags untouched
        endcase
    end

    upd78_alu_muldiv #(
        .W  (W),
        .CW (CW)
    ) u_muldiv (
        .i_clk       (CLK),
        .i_rst_n     (RESETB),
        .i_ce        (CE),
        .i_start_mul (w_start_mul),
        .i_start_div (w_start_div),
        .i_a         (AI),
        .i_b         (BI),
        .o_busy      (w_busy),
        .o_done      (w_md_done),
        .o_is_mul    (w_md_is_mul),
        .o_lo        (w_md_lo),
        .o_hi        (w_md_hi)
    );

    // Output registers: capture a single-cycle result at issue or MUL/DIV at completion.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_co   <= '0;
            r_coh  <= '0;
            r_cco  <= 1'b0;
            r_cho  <= 1'b0;
            r_zo   <= 1'b0;
            r_vo   <= 1'b0;
            r_done <= 1'b0;
        end else if (CE) begin
            r_done <= 1'b0;
            if (w_md_done) begin
                r_co   <= w_md_lo;
                r_coh  <= w_md_hi;
                r_cco  <= w_md_is_mul ? (|w_md_hi) : 1'b0;
                r_cho  <= 1'b0;
                r_vo   <= 1'b0;
                r_zo   <= (w_md_lo == '0) && (!w_md_is_mul || (w_md_hi == '0));
                r_done <= 1'b1;
            end else if (w_issue_sc) begin
                r_co   <= w_res;
                r_coh  <= w_resh;
                r_cco  <= w_cco;
                r_cho  <= w_cho;
                r_vo   <= w_vo;
                r_zo   <= (w_res == '0);
                r_done <= 1'b1;
            end
        end
    end

    assign BUSY = w_busy;
    assign DONE = r_done;
    assign CO   = r_co;
    assign COH  = r_coh;
    assign CCO  = r_cco;
    assign CHO  = r_cho;
    assign ZO   = r_zo;
    assign VO   = r_vo;

endmodule
